mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Two-requester controller for the single shared data-memory port. Arbitrates IFU instruction fetches
//  against LSU loads/stores, sequences one transaction at a time through a request/response
//  valid-ready handshake, and routes the response back to the owner. Adds a response timeout
//  that converts a hung memory into an error response. Sits between IFU/LSU and the SRAM model.
// PARAMETERS
//  ADDR_W   32   address width
//  DATA_W   32   read/write data width
//  MASK_W   8    write byte-mask width (matches LSU wmask)
//  TIMEOUT  255  max cycles in WAIT_RSP before error response; 0 disables the timeout
// PORTS
//  clk            in   1       single clock, rising edge
//  rst            in   1       synchronous, active-low reset
//  ifu_req_valid  in   1       IFU fetch request
//  ifu_req_ready  out  1       IFU request accepted this cycle
//  ifu_addr       in   ADDR_W  fetch address
//  ifu_rsp_valid  out  1       fetch data available
//  ifu_rsp_ready  in   1       IFU takes response
//  ifu_rdata      out  DATA_W  fetched word
//  ifu_rsp_err    out  1       fetch timed out
//  lsu_req_valid  in   1       LSU request
//  lsu_req_ready  out  1       LSU request accepted this cycle
//  lsu_wen        in   1       1 = store, 0 = load
//  lsu_addr       in   ADDR_W  load/store address
//  lsu_wdata      in   DATA_W  store data
//  lsu_wmask      in   MASK_W  store byte mask
//  lsu_rsp_valid  out  1       load data / store ack available
//  lsu_rsp_ready  in   1       LSU takes response
//  lsu_rdata      out  DATA_W  load word (raw; LSU extends/masks); 0 for stores
//  lsu_rsp_err    out  1       access timed out
//  mem_req_valid  out  1       request to memory
//  mem_req_ready  in   1       memory accepts request
//  mem_wen        out  1       store
//  mem_addr       out  ADDR_W  address
//  mem_wdata      out  DATA_W  store data
//  mem_wmask      out  MASK_W  store mask; 0 on loads/fetches
//  mem_rsp_valid  in   1       memory response (read data or write ack)
//  mem_rsp_ready  out  1       block accepts response
//  mem_rdata      in   DATA_W  read data
// BEHAVIOUR
//  - rst low at an edge: state IDLE, all valid/ready/err outputs 0, data outputs 0, last_owner=IFU,
//    timeout count 0, in-flight transaction discarded. Same result in any state (mid-operation).
//  - FSM IDLE -> SEND -> WAIT_RSP -> DELIVER -> IDLE. One transaction outstanding at a time.
//  - IDLE: grant is combinational from the req_valid inputs; only the granted client sees req_ready=1.
//    Both valid: grant the client that is not last_owner (round-robin). After reset, LSU wins the first
//    tie. On handshake: latch owner, addr, wen, wdata, wmask (mask forced 0 for IFU and loads);
//    last_owner<=owner; go to SEND.
//  - SEND: mem_req_valid=1, mem_* held stable from latches; on mem_req_ready go to WAIT_RSP.
//    No timeout in SEND.
//  - WAIT_RSP: mem_rsp_ready=1; counter increments each cycle. mem_rsp_valid: latch rdata
//    (0 if store), err=0, go to DELIVER. Count reaches TIMEOUT (TIMEOUT!=0) with no response:
//    rdata=0, err=1, go to DELIVER. A response in the same cycle as the timeout wins (err=0).
//  - DELIVER: owner rsp_valid=1 with registered rdata/err; the non-owner rsp_valid stays 0.
//    On owner rsp_ready go to IDLE. A new grant is possible the cycle after (no back-to-back in DELIVER).
//  - Minimum latency: accepted in cycle N; mem_req_valid in N+1; with ready/rsp_valid tied high,
//    rsp_valid in N+3; next grant in N+4.
//  - mem_rsp_ready=0 outside WAIT_RSP. A memory response arriving after a timeout is not defined
//    behaviour for this block (memory is required not to do it).
//  - All outputs are driven from registered state/latches except req_ready (a function of state and
//    the req_valid inputs).
// STRUCTURE
//  - npc_mem_pkg: arb_state_e {IDLE,SEND,WAIT_RSP,DELIVER}, owner_e {OWN_IFU,OWN_LSU}, width localparams.
//  - Sub-module rr_arbiter2: 2-way round-robin grant from (req[1:0], last_owner) -> gnt[1:0].
//  - Top: FSM, transaction latches, timeout counter ($clog2(TIMEOUT+1) bits), response mux.
// TESTING
//  - IFU only, addr 0x80000000, mem ready/rsp immediate, rdata 0x00000413 -> ifu_rsp_valid at N+3,
//    rdata 0x00000413, err 0.
//  - LSU store addr 0x80001000, wdata 0xDEADBEEF, wmask 0x0F -> mem sees wen=1 and the same fields;
//    lsu_rdata 0 and lsu_rsp_valid after the ack.
//  - Both valid every cycle for 6 transactions -> grants LSU,IFU,LSU,IFU,LSU,IFU; each response goes to
//    its own owner only.
//  - TIMEOUT=4, memory never asserts rsp_valid -> 4 cycles in WAIT_RSP, then owner rsp_valid=1, err=1,
//    rdata 0.
//  - mem_req_ready held low 10 cycles, then lsu_rsp_ready held low 3 cycles -> mem_* and rsp outputs
//    stable throughout; no timeout.
//  - rst low during WAIT_RSP -> next cycle IDLE, all valids 0; next tie grants LSU.

Source files
------------

// File: rtl/npc_mem_pkg.sv
// Shared state/owner types and default widths for the data-memory port arbiter.
package npc_mem_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND     = 2'd1,
        WAIT_RSP = 2'd2,
        DELIVER  = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_e;

    localparam int ADDR_W_DEF  = 32;
    localparam int DATA_W_DEF  = 32;
    localparam int MASK_W_DEF  = 8;
    localparam int TIMEOUT_DEF = 255;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: bit 0 = IFU, bit 1 = LSU; ties go to whoever did not own last.
module rr_arbiter2 (
    input  logic [1:0] i_req,
    input  logic       i_last_lsu,
    output logic [1:0] o_gnt
);

    always_comb begin
        o_gnt = 2'b00;
        case (i_req)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            2'b11:   o_gnt = i_last_lsu ? 2'b01 : 2'b10;
            default: o_gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between IFU and LSU: one transaction in flight, response routed
// back to its owner, and a WAIT_RSP timeout that turns a hung memory into an error response.
module mem_port_arbiter
    import npc_mem_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int MASK_W  = MASK_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [ADDR_W-1:0] ifu_addr,
    output logic              ifu_rsp_valid,
    input  logic              ifu_rsp_ready,
    output logic [DATA_W-1:0] ifu_rdata,
    output logic              ifu_rsp_err,
    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic              lsu_wen,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [MASK_W-1:0] lsu_wmask,
    output logic              lsu_rsp_valid,
    input  logic              lsu_rsp_ready,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic              lsu_rsp_err,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [MASK_W-1:0] mem_wmask,
    input  logic              mem_rsp_valid,
    output logic              mem_rsp_ready,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    arb_state_e        r_state;
    arb_state_e        w_state_nxt;
    owner_e            r_owner;
    owner_e            r_last_owner;
    logic              r_wen;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [MASK_W-1:0] r_wmask;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;
    logic [CNT_W-1:0]  r_cnt;
    logic [1:0]        w_gnt;
    logic              w_req_fire;
    logic              w_cnt_hit;
    logic              w_own_rsp_ready;

    rr_arbiter2 u_rr (
        .i_req      ({lsu_req_valid, ifu_req_valid}),
        .i_last_lsu (r_last_owner == OWN_LSU),
        .o_gnt      (w_gnt)
    );

    assign ifu_req_ready   = (r_state == IDLE) && w_gnt[0];
    assign lsu_req_ready   = (r_state == IDLE) && w_gnt[1];
    assign w_req_fire      = ifu_req_ready || lsu_req_ready;
    // Fires on the TIMEOUT-th WAIT_RSP cycle; a response in that same cycle still wins.
    assign w_cnt_hit       = (TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT - 1));
    assign w_own_rsp_ready = (r_owner == OWN_LSU) ? lsu_rsp_ready : ifu_rsp_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:     if (w_req_fire) w_state_nxt = SEND;
            SEND:     if (mem_req_ready) w_state_nxt = WAIT_RSP;
            WAIT_RSP: if (mem_rsp_valid || w_cnt_hit) w_state_nxt = DELIVER;
            DELIVER:  if (w_own_rsp_ready) w_state_nxt = IDLE;
            default:  w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_owner      <= OWN_IFU;
            r_last_owner <= OWN_IFU;
            r_wen        <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_wmask      <= '0;
            r_rdata      <= '0;
            r_err        <= 1'b0;
            r_cnt        <= '0;
        end else begin
            if (w_req_fire) begin
                r_owner      <= lsu_req_ready ? OWN_LSU : OWN_IFU;
                r_last_owner <= lsu_req_ready ? OWN_LSU : OWN_IFU;
                if (lsu_req_ready) begin
                    r_wen   <= lsu_wen;
                    r_addr  <= lsu_addr;
                    r_wdata <= lsu_wdata;
                    r_wmask <= lsu_wen ? lsu_wmask : '0;
                end else begin
                    r_wen   <= 1'b0;
                    r_addr  <= ifu_addr;
                    r_wdata <= '0;
                    r_wmask <= '0;
                end
            end
            if (r_state == WAIT_RSP) begin
                r_cnt <= r_cnt + 1'b1;
                if (mem_rsp_valid) begin
                    r_rdata <= r_wen ? '0 : mem_rdata;
                    r_err   <= 1'b0;
                end else if (w_cnt_hit) begin
                    r_rdata <= '0;
                    r_err   <= 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign mem_req_valid = (r_state == SEND);
    assign mem_rsp_ready = (r_state == WAIT_RSP);
    assign mem_wen       = r_wen;
    assign mem_addr      = r_addr;
    assign mem_wdata     = r_wdata;
    assign mem_wmask     = r_wmask;

    assign ifu_rsp_valid = (r_state == DELIVER) && (r_owner == OWN_IFU);
    assign lsu_rsp_valid = (r_state == DELIVER) && (r_owner == OWN_LSU);
    assign ifu_rsp_err   = ifu_rsp_valid && r_err;
    assign lsu_rsp_err   = lsu_rsp_valid && r_err;
    assign ifu_rdata     = r_rdata;
    assign lsu_rdata     = r_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter (TIMEOUT=4): vector table, multi-cycle corner sequences, and a
// randomized run against a transaction-level scoreboard.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_ready, ifu_rsp_err;
    logic [31:0] ifu_addr, ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid, lsu_rsp_ready, lsu_rsp_err;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [7:0]  lsu_wmask;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid, mem_rsp_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  mem_wmask;

    int n_chk  = 0;
    int n_fail = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MASK_W(8), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready), .ifu_rdata(ifu_rdata),
        .ifu_rsp_err(ifu_rsp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_wen(lsu_wen),
        .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready), .lsu_rdata(lsu_rdata),
        .lsu_rsp_err(lsu_rsp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          iv;
        bit          lv;
        bit          wen;
        logic [31:0] iaddr;
        logic [31:0] laddr;
        logic [31:0] wdata;
        logic [7:0]  wmask;
        logic [31:0] mrdata;
        bit          exp_lsu;
        bit          exp_wen;
        logic [31:0] exp_addr;
        logic [7:0]  exp_mask;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        bit          wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [7:0]  mask;
    } mreq_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mhash(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_1234;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        next_cycle();
        next_cycle();
        rst = 1'b1;
    endtask

    task automatic check_idle_outs(input string tag);
        @(negedge clk);
        check({tag, "_mem_req_valid"}, mem_req_valid, 0);
        check({tag, "_mem_rsp_ready"}, mem_rsp_ready, 0);
        check({tag, "_rsp_valids"}, {ifu_rsp_valid, lsu_rsp_valid}, 0);
        check({tag, "_rsp_errs"}, {ifu_rsp_err, lsu_rsp_err}, 0);
        check({tag, "_mem_fields"}, {mem_wen, mem_wmask, mem_addr}, 0);
        check({tag, "_mem_wdata"}, mem_wdata, 0);
        check({tag, "_rdata"}, {ifu_rdata, lsu_rdata}, 0);
    endtask

    // One transaction with memory ready and responding immediately, checked cycle by cycle.
    task automatic do_txn(input string tag, input vec_t v);
        ifu_req_valid = v.iv;  ifu_addr = v.iaddr;
        lsu_req_valid = v.lv;  lsu_wen = v.wen;  lsu_addr = v.laddr;
        lsu_wdata = v.wdata;   lsu_wmask = v.wmask;
        mem_req_ready = 1'b1;  mem_rsp_valid = 1'b1;  mem_rdata = v.mrdata;
        ifu_rsp_ready = 1'b1;  lsu_rsp_ready = 1'b1;
        @(negedge clk);
        check({tag, "_grant"}, {ifu_req_ready, lsu_req_ready}, v.exp_lsu ? 2'b01 : 2'b10);
        next_cycle();
        ifu_req_valid = 1'b0;  lsu_req_valid = 1'b0;
        @(negedge clk);
        check({tag, "_n1_req_valid"}, {mem_req_valid, mem_rsp_ready}, 2'b10);
        check({tag, "_n1_fields"}, {mem_wen, mem_wmask, mem_addr}, {v.exp_wen, v.exp_mask, v.exp_addr});
        if (v.exp_wen) check({tag, "_n1_wdata"}, mem_wdata, v.wdata);
        next_cycle();
        @(negedge clk);
        check({tag, "_n2_wait"}, {mem_req_valid, mem_rsp_ready, ifu_rsp_valid, lsu_rsp_valid}, 4'b0100);
        next_cycle();
        @(negedge clk);
        check({tag, "_n3_valid"}, {ifu_rsp_valid, lsu_rsp_valid}, v.exp_lsu ? 2'b01 : 2'b10);
        check({tag, "_n3_rdata"}, v.exp_lsu ? lsu_rdata : ifu_rdata, v.exp_rdata);
        check({tag, "_n3_err"}, {ifu_rsp_err, lsu_rsp_err}, 0);
        next_cycle();
        @(negedge clk);
        check({tag, "_n4_idle"}, {ifu_rsp_valid, lsu_rsp_valid, mem_req_valid}, 0);
        next_cycle();
    endtask

    // IFU fetch whose response arrives in WAIT_RSP cycle rsp_at (0 = never).
    task automatic wait_case(input string tag, input int rsp_at, input logic [31:0] rd,
                             input bit exp_err, input int exp_waits);
        int waits;
        waits = 0;
        ifu_req_valid = 1'b1;  ifu_addr = 32'h8000_0100;
        mem_req_ready = 1'b1;  mem_rsp_valid = 1'b0;  mem_rdata = rd;
        ifu_rsp_ready = 1'b1;
        next_cycle();
        ifu_req_valid = 1'b0;
        next_cycle();
        for (int c = 1; c <= 10; c++) begin
            mem_rsp_valid = (c == rsp_at);
            @(negedge clk);
            if (!mem_rsp_ready) break;
            waits++;
            next_cycle();
        end
        mem_rsp_valid = 1'b0;
        check({tag, "_wait_cycles"}, waits, exp_waits);
        check({tag, "_valid"}, {ifu_rsp_valid, lsu_rsp_valid}, 2'b10);
        check({tag, "_err"}, ifu_rsp_err, exp_err);
        check({tag, "_rdata"}, ifu_rdata, exp_err ? 32'h0 : rd);
        next_cycle();
    endtask

    task automatic stall_case();
        lsu_req_valid = 1'b1;  lsu_wen = 1'b1;  lsu_addr = 32'h8000_3000;
        lsu_wdata = 32'h1122_3344;  lsu_wmask = 8'hF0;
        mem_req_ready = 1'b0;  mem_rsp_valid = 1'b1;  mem_rdata = 32'h9999_9999;
        lsu_rsp_ready = 1'b0;
        @(negedge clk);
        check("stall_grant", {ifu_req_ready, lsu_req_ready}, 2'b01);
        next_cycle();
        lsu_req_valid = 1'b0;  ifu_req_valid = 1'b1;  ifu_addr = 32'h8000_0200;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_send_fields", {mem_req_valid, mem_wen, mem_wmask, mem_addr},
                  {2'b11, 8'hF0, 32'h8000_3000});
            check("stall_send_wdata", mem_wdata, 32'h1122_3344);
            check("stall_send_quiet", {ifu_req_ready, lsu_rsp_valid, lsu_rsp_err, mem_rsp_ready}, 0);
            next_cycle();
        end
        mem_req_ready = 1'b1;
        next_cycle();
        @(negedge clk);
        check("stall_wait", {mem_req_valid, mem_rsp_ready}, 2'b01);
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_deliver", {lsu_rsp_valid, lsu_rsp_err, ifu_rsp_valid, ifu_req_ready}, 4'b1000);
            check("stall_deliver_rdata", lsu_rdata, 32'h0);
            next_cycle();
        end
        ifu_req_valid = 1'b0;  lsu_rsp_ready = 1'b1;
        @(negedge clk);
        check("stall_release", lsu_rsp_valid, 1'b1);
        next_cycle();
        @(negedge clk);
        check("stall_done", {lsu_rsp_valid, mem_req_valid}, 0);
        next_cycle();
    endtask

    task automatic reset_mid_wait();
        vec_t tie;
        lsu_req_valid = 1'b1;  lsu_wen = 1'b0;  lsu_addr = 32'h8000_4000;
        mem_req_ready = 1'b1;  mem_rsp_valid = 1'b0;
        next_cycle();
        lsu_req_valid = 1'b0;
        next_cycle();
        @(negedge clk);
        check("rstw_in_wait", mem_rsp_ready, 1'b1);
        next_cycle();
        rst = 1'b0;
        next_cycle();
        rst = 1'b1;
        check_idle_outs("rstw");
        next_cycle();
        tie = '{1'b1, 1'b1, 1'b0, 32'h8000_0300, 32'h8000_6000, 32'h0, 8'hFF, 32'h7777_0000,
                1'b1, 1'b0, 32'h8000_6000, 8'h00, 32'h7777_0000};
        do_txn("rstw_tie", tie);
    endtask

    task automatic run_random();
        bit          ip, lp, lw, win_lsu, exp_lsu, rsp_pend, cur_wen;
        logic [31:0] ia, la, lwd, cur_addr, exp_rd;
        logic [7:0]  lm;
        int          rsp_cnt, done_i, done_l;
        bit          last_lsu;
        mreq_t       mq[$];
        mreq_t       e;
        logic [31:0] iq[$];
        logic [31:0] lq[$];
        ip = 0; lp = 0; lw = 0; rsp_pend = 0; cur_wen = 0; last_lsu = 0;
        ia = 0; la = 0; lwd = 0; lm = 0; cur_addr = 0; rsp_cnt = 0; done_i = 0; done_l = 0;
        for (int cyc = 0; cyc < 700; cyc++) begin
            if (!ip && cyc < 450 && $urandom_range(0, 2) == 0) begin
                ip = 1;  ia = $urandom;
            end
            if (!lp && cyc < 450 && $urandom_range(0, 2) == 0) begin
                lp = 1;  la = $urandom;  lw = 1'($urandom_range(0, 1));
                lwd = $urandom;  lm = 8'($urandom);
            end
            ifu_req_valid = ip;  ifu_addr = ia;
            lsu_req_valid = lp;  lsu_addr = la;  lsu_wen = lw;  lsu_wdata = lwd;  lsu_wmask = lm;
            mem_req_ready = ($urandom_range(0, 3) != 0);
            if (rsp_pend && rsp_cnt == 0) begin
                mem_rsp_valid = 1'b1;
                mem_rdata = cur_wen ? $urandom : mhash(cur_addr);
            end else begin
                mem_rsp_valid = 1'b0;
                mem_rdata = $urandom;
                if (rsp_pend) rsp_cnt--;
            end
            ifu_rsp_ready = 1'($urandom_range(0, 1));
            lsu_rsp_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("rnd_one_grant", ifu_req_ready & lsu_req_ready, 0);
            check("rnd_rsp_exclusive", ifu_rsp_valid & lsu_rsp_valid, 0);
            if ((ifu_req_valid && ifu_req_ready) || (lsu_req_valid && lsu_req_ready)) begin
                win_lsu = lsu_req_valid && lsu_req_ready;
                exp_lsu = (ip && lp) ? !last_lsu : lp;
                check("rnd_rr_grant", win_lsu, exp_lsu);
                last_lsu = win_lsu;
                if (win_lsu) begin
                    mq.push_back('{lw, la, lwd, lw ? lm : 8'h00});
                    lq.push_back(lw ? 32'h0 : mhash(la));
                    lp = 0;
                end else begin
                    mq.push_back('{1'b0, ia, 32'h0, 8'h00});
                    iq.push_back(mhash(ia));
                    ip = 0;
                end
            end
            if (mem_req_valid && mem_req_ready) begin
                check("rnd_mem_req_expected", mq.size() != 0, 1);
                if (mq.size() != 0) begin
                    e = mq.pop_front();
                    check("rnd_mem_fields", {mem_wen, mem_wmask, mem_addr}, {e.wen, e.mask, e.addr});
                    if (e.wen) check("rnd_mem_wdata", mem_wdata, e.wdata);
                    cur_wen = e.wen;  cur_addr = e.addr;
                    rsp_pend = 1;  rsp_cnt = $urandom_range(0, 3);
                end
            end
            if (mem_rsp_valid && mem_rsp_ready) rsp_pend = 0;
            if (ifu_rsp_valid && ifu_rsp_ready) begin
                check("rnd_ifu_rsp_expected", iq.size() != 0, 1);
                if (iq.size() != 0) begin
                    exp_rd = iq.pop_front();
                    check("rnd_ifu_rsp", {ifu_rsp_err, ifu_rdata}, {1'b0, exp_rd});
                    done_i++;
                end
            end
            if (lsu_rsp_valid && lsu_rsp_ready) begin
                check("rnd_lsu_rsp_expected", lq.size() != 0, 1);
                if (lq.size() != 0) begin
                    exp_rd = lq.pop_front();
                    check("rnd_lsu_rsp", {lsu_rsp_err, lsu_rdata}, {1'b0, exp_rd});
                    done_l++;
                end
            end
            next_cycle();
        end
        check("rnd_drained", {ip, lp, mq.size() == 0, iq.size() == 0, lq.size() == 0}, 5'b00111);
        check("rnd_progress", (done_i > 10) && (done_l > 10), 1);
    endtask

    initial begin
        rst = 1'b1;
        ifu_req_valid = 0; ifu_addr = 0; ifu_rsp_ready = 0;
        lsu_req_valid = 0; lsu_wen = 0; lsu_addr = 0; lsu_wdata = 0; lsu_wmask = 0; lsu_rsp_ready = 0;
        mem_req_ready = 0; mem_rsp_valid = 0; mem_rdata = 0;

        vecs[0] = '{1'b0, 1'b1, 1'b1, 32'h0, 32'h8000_1000, 32'hDEAD_BEEF, 8'h0F, 32'h1234_5678,
                    1'b1, 1'b1, 32'h8000_1000, 8'h0F, 32'h0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h8000_2004, 32'h0BAD_F00D, 8'hFF, 32'hCAFE_F00D,
                    1'b1, 1'b0, 32'h8000_2004, 8'h00, 32'hCAFE_F00D};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 32'h8000_0000, 32'h0, 32'h0, 8'h00, 32'h0000_0413,
                    1'b0, 1'b0, 32'h8000_0000, 8'h00, 32'h0000_0413};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 32'h8000_0010, 32'h8000_5000, 32'h0, 8'hFF, 32'h1111_0000,
                    1'b1, 1'b0, 32'h8000_5000, 8'h00, 32'h1111_0000};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 32'h8000_0014, 32'h8000_5004, 32'hA5A5_A5A5, 8'h3C, 32'h2222_0000,
                    1'b0, 1'b0, 32'h8000_0014, 8'h00, 32'h2222_0000};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 32'h8000_0018, 32'h8000_5008, 32'h5A5A_5A5A, 8'hC3, 32'h3333_0000,
                    1'b1, 1'b1, 32'h8000_5008, 8'hC3, 32'h0};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 32'h8000_001C, 32'h8000_500C, 32'h0, 8'h01, 32'h4444_0000,
                    1'b0, 1'b0, 32'h8000_001C, 8'h00, 32'h4444_0000};
        vecs[7] = '{1'b1, 1'b1, 1'b0, 32'h8000_0020, 32'h8000_5010, 32'h0, 8'hFF, 32'h5555_0000,
                    1'b1, 1'b0, 32'h8000_5010, 8'h00, 32'h5555_0000};
        vecs[8] = '{1'b1, 1'b1, 1'b1, 32'h8000_0024, 32'h8000_5014, 32'h0102_0304, 8'h80, 32'h6666_0000,
                    1'b0, 1'b0, 32'h8000_0024, 8'h00, 32'h6666_0000};

        next_cycle();
        apply_reset();
        check_idle_outs("reset");
        next_cycle();

        for (int i = 0; i < 9; i++) do_txn($sformatf("vec%0d", i), vecs[i]);

        wait_case("rsp_at3", 3, 32'hABCD_0003, 1'b0, 3);
        wait_case("timeout", 0, 32'hFFFF_FFFF, 1'b1, 4);
        wait_case("rsp_at4", 4, 32'hABCD_0004, 1'b0, 4);
        wait_case("rsp_at1", 1, 32'hABCD_0001, 1'b0, 1);

        stall_case();
        reset_mid_wait();

        apply_reset();
        next_cycle();
        run_random();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
